// File: rtl/cook_timer_pkg.sv
// Shared types and constants for the cook timer.
package cook_timer_pkg;

  // Timer state; encodings are fixed so the display/blink logic can decode them.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSet  = 2'd1,
    StRun  = 2'd2,
    StDone = 2'd3
  } state_e;

  localparam logic [3:0] BcdMax      = 4'd9;
  localparam logic [3:0] SecTensWrap = 4'd5;

endpackage

// File: rtl/cook_timer_if.sv
// Keypad/control-stage/display signal bundle for the cook timer.
interface cook_timer_if;
  logic       clearn;
  logic       key_valid;
  logic [3:0] key_digit;
  logic       mag_on;
  logic       timer_done;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;

  modport master (
    output clearn, key_valid, key_digit, mag_on,
    input  timer_done, min_tens, min_ones, sec_tens, sec_ones
  );

  modport slave (
    input  clearn, key_valid, key_digit, mag_on,
    output timer_done, min_tens, min_ones, sec_tens, sec_ones
  );
endinterface

// File: rtl/cook_timer_tick_gen.sv
// Prescaler with enable and sync clear; emits a one-cycle tick on wrap.
module cook_timer_tick_gen #(
  parameter int unsigned TICK_DIV = 1000,
  parameter int unsigned CNT_W    = 10
) (
  input  logic clk,
  input  logic resetn,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam logic [CNT_W-1:0] TermCnt = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Tick fires on the same edge the counter wraps.
  always_comb begin
    tick_o = en_i && (cnt_q == TermCnt);
    cnt_d  = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Counter register, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/cook_timer.sv
// MM:SS cook timer: BCD keypad entry, 1 Hz countdown gated by mag_on.
module cook_timer
  import cook_timer_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1000,
  parameter int unsigned CNT_W    = 10
) (
  input logic         clk,
  input logic         resetn,
  cook_timer_if.slave bus
);

  state_e     state_q, state_d;
  logic [3:0] mt_q, mo_q, st_q, so_q;
  logic [3:0] mt_d, mo_d, st_d, so_d;
  logic [3:0] dec_mt, dec_mo, dec_st, dec_so;
  logic       key_acc, run_en, tick, pre_clr, dec_zero;

  assign key_acc = bus.clearn && bus.key_valid && !bus.mag_on && (bus.key_digit <= BcdMax);
  // Counting happens on every mag_on cycle of a loaded timer, including the SET->RUN edge.
  assign run_en  = bus.clearn && bus.mag_on && ((state_q == StSet) || (state_q == StRun));
  assign pre_clr = !bus.clearn || key_acc;

  cook_timer_tick_gen #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) u_tick_gen (
    .clk    (clk),
    .resetn (resetn),
    .en_i   (run_en),
    .clr_i  (pre_clr),
    .tick_o (tick)
  );

  // One-second BCD decrement; seconds tens above 5 count down naturally.
  always_comb begin
    dec_mt = mt_q;
    dec_mo = mo_q;
    dec_st = st_q;
    dec_so = so_q;
    if (so_q != 4'd0) begin
      dec_so = so_q - 4'd1;
    end else begin
      dec_so = BcdMax;
      if (st_q != 4'd0) begin
        dec_st = st_q - 4'd1;
      end else begin
        dec_st = SecTensWrap;
        if (mo_q != 4'd0) begin
          dec_mo = mo_q - 4'd1;
        end else begin
          dec_mo = BcdMax;
          dec_mt = mt_q - 4'd1;
        end
      end
    end
    dec_zero = ({dec_mt, dec_mo, dec_st, dec_so} == 16'd0);
  end

  // Next state: clear > key entry > countdown > pause/resume.
  always_comb begin
    state_d = state_q;
    mt_d    = mt_q;
    mo_d    = mo_q;
    st_d    = st_q;
    so_d    = so_q;
    if (!bus.clearn) begin
      state_d = StIdle;
      {mt_d, mo_d, st_d, so_d} = '0;
    end else if (key_acc) begin
      {mt_d, mo_d, st_d, so_d} = {mo_q, st_q, so_q, bus.key_digit};
      state_d = ({mo_q, st_q, so_q, bus.key_digit} != 16'd0) ? StSet : StIdle;
    end else if (tick) begin
      {mt_d, mo_d, st_d, so_d} = {dec_mt, dec_mo, dec_st, dec_so};
      state_d = dec_zero ? StDone : StRun;
    end else if ((state_q == StSet) || (state_q == StRun)) begin
      state_d = bus.mag_on ? StRun : StSet;
    end
  end

  // State and digit registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StIdle;
      mt_q    <= '0;
      mo_q    <= '0;
      st_q    <= '0;
      so_q    <= '0;
    end else begin
      state_q <= state_d;
      mt_q    <= mt_d;
      mo_q    <= mo_d;
      st_q    <= st_d;
      so_q    <= so_d;
    end
  end

  // Done is a pure decode of the displayed digits.
  always_comb begin
    bus.min_tens   = mt_q;
    bus.min_ones   = mo_q;
    bus.sec_tens   = st_q;
    bus.sec_ones   = so_q;
    bus.timer_done = ({mt_q, mo_q, st_q, so_q} == 16'd0);
  end

endmodule

// File: tb/tb_cook_timer.sv
// Bench for cook_timer: directed plan plus random traffic against a decimal-arithmetic model.
module tb_cook_timer;

  localparam int TickDiv = 4;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  cook_timer_if bus ();

  cook_timer #(
    .TICK_DIV (TickDiv),
    .CNT_W    (3)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model: time as a 4-digit decimal number MMSS, state 0..3 (idle/set/run/done).
  int m_val = 0;
  int m_st  = 0;
  int m_pre = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int to_bcd(input int v);
    return ((v / 1000) << 12) | (((v / 100) % 10) << 8) | (((v / 10) % 10) << 4) | (v % 10);
  endfunction

  function automatic int shown();
    return int'({bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones});
  endfunction

  task automatic model_step(input logic rn, input logic cn, input logic kv,
                            input logic [3:0] kd, input logic mo);
    if (!rn || !cn) begin
      m_val = 0; m_st = 0; m_pre = 0;
    end else if (kv && !mo && kd <= 9) begin
      m_val = (m_val * 10 + int'(kd)) % 10000;
      m_pre = 0;
      m_st  = (m_val != 0) ? 1 : 0;
    end else if ((m_st == 1 || m_st == 2) && mo) begin
      m_st = 2;
      m_pre++;
      if (m_pre == TickDiv) begin
        m_pre = 0;
        m_val = (m_val % 100 != 0) ? m_val - 1 : m_val - 100 + 59;
        if (m_val == 0) m_st = 3;
      end
    end else if (m_st == 2) begin
      m_st = 1;
    end
  endtask

  task automatic cyc(input logic rn, input logic cn, input logic kv,
                     input logic [3:0] kd, input logic mo);
    resetn        = rn;
    bus.clearn    = cn;
    bus.key_valid = kv;
    bus.key_digit = kd;
    bus.mag_on    = mo;
    @(posedge clk);
    model_step(rn, cn, kv, kd, mo);
    #1;
    chk("digits", shown(), to_bcd(m_val));
    chk("timer_done", int'(bus.timer_done), int'(m_val == 0));
    chk("state", int'(dut.state_q), m_st);
    chk("prescaler", int'(dut.u_tick_gen.cnt_q), m_pre);
  endtask

  task automatic key(input logic [3:0] d);
    cyc(1'b1, 1'b1, 1'b1, d, 1'b0);
  endtask

  task automatic hold(input logic mo, input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 1'b0, 4'd0, mo);
  endtask

  task automatic clr();
    cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  logic rn_r, cn_r, kv_r, mo_r;
  logic [3:0] kd_r;

  initial begin
    // Reset
    cyc(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    chk("reset_digits", shown(), 16'h0000);
    chk("reset_done", int'(bus.timer_done), 1);
    chk("reset_state", int'(dut.state_q), 0);

    // Entry, invalid digit, key while mag_on
    key(4'd1); key(4'd3); key(4'd0);
    chk("entry_0130", shown(), 16'h0130);
    chk("entry_done", int'(bus.timer_done), 0);
    chk("entry_state", int'(dut.state_q), 1);
    key(4'd12);
    chk("key12_ignored", shown(), 16'h0130);
    cyc(1'b1, 1'b1, 1'b1, 4'd5, 1'b1);
    chk("key_magon_ignored", shown(), 16'h0130);
    clr();

    // Minute borrow
    key(4'd1); key(4'd0); key(4'd0);
    hold(1'b1, 4);
    chk("borrow_0059", shown(), 16'h0059);
    hold(1'b1, 8);
    chk("borrow_0057", shown(), 16'h0057);
    clr();

    // 10:00 -> 09:59 and 00:90 -> 00:89
    key(4'd1); key(4'd0); key(4'd0); key(4'd0);
    hold(1'b1, 4);
    chk("dec_0959", shown(), 16'h0959);
    clr();
    key(4'd9); key(4'd0);
    hold(1'b1, 4);
    chk("dec_0089", shown(), 16'h0089);
    clr();

    // Pause/resume
    key(4'd3);
    hold(1'b1, 6);
    chk("pause_0002", shown(), 16'h0002);
    chk("pause_pre", int'(dut.u_tick_gen.cnt_q), 2);
    hold(1'b0, 10);
    chk("paused_hold", shown(), 16'h0002);
    chk("paused_state", int'(dut.state_q), 1);
    hold(1'b1, 2);
    chk("resume_0001", shown(), 16'h0001);
    clr();

    // Done without wrap
    key(4'd1);
    hold(1'b1, 4);
    chk("done_0000", shown(), 16'h0000);
    chk("done_flag", int'(bus.timer_done), 1);
    chk("done_state", int'(dut.state_q), 3);
    hold(1'b1, 20);
    chk("done_nowrap", shown(), 16'h0000);
    chk("done_stays", int'(dut.state_q), 3);

    // Clear mid-run
    clr();
    key(4'd5); key(4'd0); key(4'd0);
    hold(1'b1, 9);
    cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
    chk("clear_digits", shown(), 16'h0000);
    chk("clear_state", int'(dut.state_q), 0);
    chk("clear_pre", int'(dut.u_tick_gen.cnt_q), 0);
    key(4'd7);
    chk("after_clear_0007", shown(), 16'h0007);
    chk("after_clear_state", int'(dut.state_q), 1);

    // Random traffic, biased toward short times so DONE is reached
    mo_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rn_r = ($urandom_range(0, 299) != 0);
      cn_r = ($urandom_range(0, 79) != 0);
      if ($urandom_range(0, 11) == 0) mo_r = ~mo_r;
      kv_r = ($urandom_range(0, 5) == 0);
      kd_r = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 2)) : 4'($urandom_range(0, 15));
      cyc(rn_r, cn_r, kv_r, kd_r, mo_r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
